// File: rtl/multi_seq_pkg.sv
// Shared constants, mode type and opcode legality check for the multicycle step sequencer.
package multi_seq_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [1:0] {
    ModeRun,
    ModeHalt,
    ModeTrap
  } mode_e;

  // True for every opcode the datapath implements, HALT included.
  function automatic logic op_legal(input logic [5:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_HALT: legal = 1'b1;
      default:                                                 legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multi_perf_cnt.sv
// Free-running wrap-around event counter with synchronous active-low reset.
module multi_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: bump by one on each qualifying cycle, wrapping naturally.
  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/multi_step_sequencer.sv
// Step sequencer for the multicycle MIPS core: step index, memory stalls, HALT/trap handling
// and performance counters.
module multi_step_sequencer
  import multi_seq_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter logic [2:0]  MAX_STEP = 3'd4,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [5:0]       op,
  input  logic             next_ins,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             step_en,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count
);

  logic [2:0] state_q, state_d;
  mode_e      mode_q, mode_d;
  logic       halted_q, halted_d;
  logic       illegal_q, illegal_d;

  logic run, stall, is_halt, is_bad, at_decode, dec_stop, instr_inc;

  // Step qualification; purely combinational so the datapath sees it in the same cycle.
  always_comb begin
    run       = en & (mode_q == ModeRun);
    stall     = run & mem_access & ~mem_ready;
    is_halt   = (op == HALT_OP);
    is_bad    = ~(op_legal(op) | is_halt);
    at_decode = (state_q == ST_DECODE);
    dec_stop  = at_decode & (is_halt | is_bad);
    step_en   = run & ~stall & ~dec_stop;
  end

  // Next-state: decode check takes priority, then the normal step / retire / overrun path.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    instr_inc = 1'b0;
    if (run && at_decode && is_halt) begin
      // HALT retires as an instruction and parks the step index at FETCH.
      mode_d    = ModeHalt;
      halted_d  = 1'b1;
      instr_inc = 1'b1;
      state_d   = ST_FETCH;
    end else if (run && at_decode && is_bad) begin
      mode_d    = ModeTrap;
      illegal_d = 1'b1;
    end else if (step_en) begin
      if (next_ins) begin
        state_d   = ST_FETCH;
        instr_inc = 1'b1;
      end else if (state_q == MAX_STEP) begin
        // Ran past the last legal step without an end-of-instruction flag.
        mode_d    = ModeTrap;
        illegal_d = 1'b1;
      end else begin
        state_d = state_q + 3'd1;
      end
    end
  end

  // Sequencer FSM register: step index, mode and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      mode_q    <= ModeRun;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign state   = state_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

  multi_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_instr_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (instr_inc),
    .count(instr_count)
  );

  multi_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_cycle_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (run),
    .count(cycle_count)
  );

  multi_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stall),
    .count(stall_count)
  );

endmodule

// File: tb/tb_multi_step_sequencer.sv
// Self-checking bench for multi_step_sequencer: directed scenarios plus a randomized run,
// all compared against a cycle-level behavioural model of the sequencer rules.
module tb_multi_step_sequencer;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_HALT = 6'b111111;
  localparam logic [5:0] T_BAD  = 6'b010001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [5:0]  op;
  logic        next_ins;
  logic        mem_access;
  logic        mem_ready;
  logic [2:0]  state;
  logic        step_en;
  logic        halted;
  logic        illegal;
  logic [31:0] instr_count;
  logic [31:0] cycle_count;
  logic [31:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: step number, mode (0 run, 1 halt, 2 trap), flags and counters.
  int          m_step;
  int          m_mode;
  logic        m_halted;
  logic        m_illegal;
  logic [31:0] m_instr;
  logic [31:0] m_cyc;
  logic [31:0] m_stl;

  multi_step_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .op         (op),
    .next_ins   (next_ins),
    .mem_access (mem_access),
    .mem_ready  (mem_ready),
    .state      (state),
    .step_en    (step_en),
    .halted     (halted),
    .illegal    (illegal),
    .instr_count(instr_count),
    .cycle_count(cycle_count),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    return o inside {T_R, T_LW, T_SW, T_BEQ, T_ADDI, T_J, T_HALT};
  endfunction

  function automatic int op_len(input logic [5:0] o);
    case (o)
      T_LW:               return 5;
      T_SW, T_R, T_ADDI:  return 4;
      T_BEQ, T_J:         return 3;
      default:            return 5;
    endcase
  endfunction

  function automatic bit model_step_en();
    bit running;
    running = en && (m_mode == 0);
    if (!running) return 0;
    if (mem_access && !mem_ready) return 0;
    if (m_step == 1 && (!is_legal(op) || op == T_HALT)) return 0;
    return 1;
  endfunction

  function automatic void model_clock();
    bit running;
    bit adv;
    running = en && (m_mode == 0);
    adv     = model_step_en();
    if (running) m_cyc = m_cyc + 1;
    if (running && mem_access && !mem_ready) m_stl = m_stl + 1;
    if (running && m_step == 1 && op == T_HALT) begin
      m_mode = 1; m_halted = 1; m_instr = m_instr + 1; m_step = 0;
    end else if (running && m_step == 1 && !is_legal(op)) begin
      m_mode = 2; m_illegal = 1;
    end else if (adv) begin
      if (next_ins) begin
        m_step = 0; m_instr = m_instr + 1;
      end else if (m_step == 4) begin
        m_mode = 2; m_illegal = 1;
      end else begin
        m_step = m_step + 1;
      end
    end
  endfunction

  task automatic check_regs();
    check("state", 64'(state), 64'(m_step));
    check("halted", 64'(halted), 64'(m_halted));
    check("illegal", 64'(illegal), 64'(m_illegal));
    check("instr_count", 64'(instr_count), 64'(m_instr));
    check("cycle_count", 64'(cycle_count), 64'(m_cyc));
    check("stall_count", 64'(stall_count), 64'(m_stl));
  endtask

  // One clock: drive at negedge, check step_en, clock the model with the DUT, check registers.
  task automatic step(input logic e, input logic [5:0] o, input logic ni, input logic ma,
                      input logic mr);
    @(negedge clk);
    en = e; op = o; next_ins = ni; mem_access = ma; mem_ready = mr;
    #1;
    check("step_en", 64'(step_en), 64'(model_step_en()));
    @(posedge clk);
    model_clock();
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'($urandom_range(0, 1)); mem_access = 1'b1; mem_ready = 1'b0; next_ins = 1'b1;
    @(posedge clk);
    m_step = 0; m_mode = 0; m_halted = 0; m_illegal = 0; m_instr = 0; m_cyc = 0; m_stl = 0;
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_flags", {62'd0, halted, illegal}, 64'd0);
    check("rst_counts", {instr_count, cycle_count} | 64'(stall_count), 64'd0);
    rst_n = 1'b1;
  endtask

  // Acts as the control decoder for one instruction; optional wait states at one step.
  task automatic instr(input logic [5:0] o, input int len, input int st_step, input int nst);
    int  left;
    int  guard;
    logic ni, ma, mr;
    left  = nst;
    guard = 0;
    do begin
      ni = (m_step == len - 1);
      ma = (m_step == 0) || (m_step == 3 && (o == T_LW || o == T_SW));
      mr = 1'b1;
      if (m_step == st_step && left > 0) begin
        mr = 1'b0;
        left--;
      end
      step(1'b1, o, ni, ma, mr);
      guard++;
    end while (m_step != 0 && m_mode == 0 && guard < 40);
    if (guard >= 40) check("instr_timeout", 64'(guard), 64'd0);
  endtask

  task automatic rand_cycle();
    step(1'($urandom_range(0, 9) != 0), 6'($urandom), 1'($urandom), 1'($urandom),
         1'($urandom));
  endtask

  function automatic logic [5:0] pick_op();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return T_HALT;
    if (r == 1) return 6'($urandom);
    case (r % 6)
      0:       return T_R;
      1:       return T_LW;
      2:       return T_SW;
      3:       return T_BEQ;
      4:       return T_ADDI;
      default: return T_J;
    endcase
  endfunction

  initial begin
    logic [5:0] cur_op;
    int         len;
    logic       ni, ma, mr;

    rst_n = 1'b1; en = 1'b0; op = '0; next_ins = 1'b0; mem_access = 1'b0; mem_ready = 1'b1;
    m_step = 0; m_mode = 0; m_halted = 0; m_illegal = 0; m_instr = 0; m_cyc = 0; m_stl = 0;

    // lw with memory always ready: five steps, one retire.
    do_reset();
    instr(T_LW, 5, 99, 0);
    check("lw_instr", 64'(instr_count), 64'd1);
    check("lw_cycles", 64'(cycle_count), 64'd5);

    // sw with two wait states at step 3.
    do_reset();
    instr(T_SW, 4, 3, 2);
    check("sw_stalls", 64'(stall_count), 64'd2);
    check("sw_instr", 64'(instr_count), 64'd1);
    check("sw_cycles", 64'(cycle_count), 64'd6);

    // Illegal opcode traps at decode and freezes everything.
    do_reset();
    instr(T_BAD, 5, 99, 0);
    for (int i = 0; i < 10; i++) rand_cycle();
    check("bad_illegal", 64'(illegal), 64'd1);
    check("bad_state", 64'(state), 64'd1);
    check("bad_cycles", 64'(cycle_count), 64'd2);

    // addi then HALT.
    do_reset();
    instr(T_ADDI, 4, 99, 0);
    instr(T_HALT, 5, 99, 0);
    check("halt_flag", 64'(halted), 64'd1);
    check("halt_instr", 64'(instr_count), 64'd2);
    for (int i = 0; i < 5; i++) rand_cycle();
    check("halt_frozen", 64'(instr_count), 64'd2);
    check("halt_state", 64'(state), 64'd0);

    // Overrun at step 4 without next_ins, then the same with next_ins.
    do_reset();
    instr(T_LW, 6, 99, 0);
    check("ovr_illegal", 64'(illegal), 64'd1);
    check("ovr_state", 64'(state), 64'd4);
    do_reset();
    instr(T_LW, 5, 99, 0);
    check("max_retire_illegal", 64'(illegal), 64'd0);
    check("max_retire_instr", 64'(instr_count), 64'd1);

    // Reset in the middle of a stall at step 2.
    do_reset();
    step(1'b1, T_LW, 1'b0, 1'b1, 1'b1);
    step(1'b1, T_LW, 1'b0, 1'b0, 1'b1);
    step(1'b1, T_LW, 1'b0, 1'b1, 1'b0);
    do_reset();

    // en dropped for three cycles mid-lw.
    step(1'b1, T_LW, 1'b0, 1'b1, 1'b1);
    step(1'b1, T_LW, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, T_LW, 1'b0, 1'b1, 1'b0);
    check("en_hold_state", 64'(state), 64'd2);
    step(1'b1, T_LW, 1'b0, 1'b0, 1'b1);
    step(1'b1, T_LW, 1'b0, 1'b1, 1'b1);
    step(1'b1, T_LW, 1'b1, 1'b0, 1'b1);
    check("en_resume_instr", 64'(instr_count), 64'd1);
    check("en_resume_cycles", 64'(cycle_count), 64'd5);

    // Randomized program-like traffic with occasional resets.
    do_reset();
    cur_op = T_R;
    for (int n = 0; n < 2000; n++) begin
      if ((m_mode != 0 && $urandom_range(0, 5) == 0) || $urandom_range(0, 299) == 0) begin
        do_reset();
      end
      if (m_step == 0) cur_op = pick_op();
      len = op_len(cur_op);
      ni  = (m_step == len - 1);
      if ($urandom_range(0, 39) == 0) ni = ~ni;
      ma  = (m_step == 0) || (m_step == 3 && (cur_op == T_LW || cur_op == T_SW));
      mr  = ($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 9) != 0), cur_op, ni, ma, mr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
